// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - shared core defines: address width, fetch FSM encoding, reset PC
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package fetch_pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator with redirect priority, pending redirect and imem handshake
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int            AW       = `ADDR_WIDTH,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic          cpu_clk,
    input  logic          cpu_rstn,
    input  logic          stall_fetch,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    output logic [AW-1:0] next_pc,
    output logic [AW-1:0] pc,
    input  logic          predict_taken,
    input  logic [AW-1:0] predict_target_pc,
    input  logic          redirect_ex,
    input  logic [AW-1:0] redirect_ex_pc,
    input  logic          redirect_dec,
    input  logic [AW-1:0] redirect_dec_pc,
    output logic          fetch_fire,
    output logic          fetch_kill,
    output logic          fetch_pred_taken
);

    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q;
    logic          pend_valid, pend_is_ex;
    logic [AW-1:0] pend_pc;
    logic          redir_valid;
    logic [AW-1:0] redir_pc;
    logic [AW-1:0] sel_pc;

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                imem_req = !stall_fetch;
                if (imem_req && !imem_gnt) state_d = ST_WAIT;
            end
            // Request stays up through a stall so the address handshake completes
            ST_WAIT: begin
                imem_req = 1'b1;
                if (imem_gnt) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        redir_valid = 1'b1;
        redir_pc    = pend_pc;
        if (redirect_ex) begin
            redir_pc = redirect_ex_pc;
        end else if (redirect_dec) begin
            redir_pc = redirect_dec_pc;
        end else begin
            redir_valid = pend_valid;
        end
    end

    assign fetch_fire       = imem_req && imem_gnt;
    assign fetch_kill       = fetch_fire && redir_valid;
    assign fetch_pred_taken = predict_taken && fetch_fire && !fetch_kill;

    always_comb begin
        sel_pc = pc_q + AW'(4);
        if (redir_valid) begin
            sel_pc = redir_pc;
        end else if (predict_taken) begin
            sel_pc = predict_target_pc;
        end
    end

    assign next_pc   = fetch_fire ? (sel_pc & ALIGN_MASK) : pc_q;
    assign pc        = pc_q;
    assign imem_addr = pc_q;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (fetch_fire) pc_q <= next_pc;
        end
    end

    // An ex redirect is older in program order than anything decode sees, so it always wins
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            pend_valid <= 1'b0;
            pend_is_ex <= 1'b0;
            pend_pc    <= '0;
        end else if (fetch_fire) begin
            pend_valid <= 1'b0;
            pend_is_ex <= 1'b0;
        end else if (redirect_ex) begin
            pend_valid <= 1'b1;
            pend_is_ex <= 1'b1;
            pend_pc    <= redirect_ex_pc;
        end else if (redirect_dec && !(pend_valid && pend_is_ex)) begin
            pend_valid <= 1'b1;
            pend_is_ex <= 1'b0;
            pend_pc    <= redirect_dec_pc;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - table-driven scoreboard bench for fetch_pc_gen
module tb_fetch_pc_gen;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic        stall_fetch;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        predict_taken;
    logic [31:0] predict_target_pc;
    logic        redirect_ex;
    logic [31:0] redirect_ex_pc;
    logic        redirect_dec;
    logic [31:0] redirect_dec_pc;
    logic        fetch_fire;
    logic        fetch_kill;
    logic        fetch_pred_taken;

    int tests = 0;
    int failed = 0;

    always #5 cpu_clk = ~cpu_clk;

    fetch_pc_gen #(.AW(32), .RESET_PC(32'h0)) dut (
        .cpu_clk          (cpu_clk),
        .cpu_rstn         (cpu_rstn),
        .stall_fetch      (stall_fetch),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .next_pc          (next_pc),
        .pc               (pc),
        .predict_taken    (predict_taken),
        .predict_target_pc(predict_target_pc),
        .redirect_ex      (redirect_ex),
        .redirect_ex_pc   (redirect_ex_pc),
        .redirect_dec     (redirect_dec),
        .redirect_dec_pc  (redirect_dec_pc),
        .fetch_fire       (fetch_fire),
        .fetch_kill       (fetch_kill),
        .fetch_pred_taken (fetch_pred_taken)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] npc;
        logic        fire;
        logic        kill;
        logic        fpt;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        pt;
        logic [31:0] ptgt;
        logic        rex;
        logic [31:0] rexpc;
        logic        rdec;
        logic [31:0] rdecpc;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic void add(input logic stall, gnt, pt, input logic [31:0] ptgt,
                                input logic rex, input logic [31:0] rexpc,
                                input logic rdec, input logic [31:0] rdecpc,
                                input logic req, input logic [31:0] addr, npc,
                                input logic fire, kill, fpt);
        vec_t v;
        v.stall = stall; v.gnt = gnt; v.pt = pt; v.ptgt = ptgt;
        v.rex = rex; v.rexpc = rexpc; v.rdec = rdec; v.rdecpc = rdecpc;
        v.e.req = req; v.e.addr = addr; v.e.npc = npc;
        v.e.fire = fire; v.e.kill = kill; v.e.fpt = fpt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, " imem_req"},  32'(imem_req), 32'(e.req));
        chk({tag, " imem_addr"}, imem_addr,     e.addr);
        chk({tag, " pc"},        pc,            e.addr);
        chk({tag, " next_pc"},   next_pc,       e.npc);
        chk({tag, " fire"},      32'(fetch_fire), 32'(e.fire));
        chk({tag, " kill"},      32'(fetch_kill), 32'(e.kill));
        chk({tag, " pred"},      32'(fetch_pred_taken), 32'(e.fpt));
    endtask

    task automatic drive(input vec_t v);
        stall_fetch       = v.stall;
        imem_gnt          = v.gnt;
        predict_taken     = v.pt;
        predict_target_pc = v.ptgt;
        redirect_ex       = v.rex;
        redirect_ex_pc    = v.rexpc;
        redirect_dec      = v.rdec;
        redirect_dec_pc   = v.rdecpc;
    endtask

    initial begin
        exp_t e;
        // stall gnt pt ptgt | rex rexpc | rdec rdecpc || req addr next_pc fire kill fpt
        add(0,1,0,0,        0,0,          0,0,          0,32'h0,   32'h0,   0,0,0); // BOOT
        add(0,1,0,0,        0,0,          0,0,          1,32'h0,   32'h4,   1,0,0);
        add(0,1,0,0,        0,0,          0,0,          1,32'h4,   32'h8,   1,0,0);
        add(0,1,1,32'h103,  0,0,          0,0,          1,32'h8,   32'h100, 1,0,1);
        add(0,1,0,0,        0,0,          0,0,          1,32'h100, 32'h104, 1,0,0);
        add(0,1,0,0,        1,32'h10,     0,0,          1,32'h104, 32'h10,  1,1,0);
        add(0,0,0,0,        0,0,          0,0,          1,32'h10,  32'h10,  0,0,0); // enter WAIT
        add(0,0,0,0,        1,32'h200,    0,0,          1,32'h10,  32'h10,  0,0,0);
        add(0,0,0,0,        0,0,          0,0,          1,32'h10,  32'h10,  0,0,0);
        add(0,1,0,0,        0,0,          0,0,          1,32'h10,  32'h200, 1,1,0);
        add(0,1,0,0,        1,32'h300,    1,32'h400,    1,32'h200, 32'h300, 1,1,0);
        add(1,1,1,32'h40,   0,0,          0,0,          0,32'h300, 32'h300, 0,0,0); // stall RUN
        add(1,1,0,0,        0,0,          0,0,          0,32'h300, 32'h300, 0,0,0);
        add(0,0,0,0,        0,0,          0,0,          1,32'h300, 32'h300, 0,0,0);
        add(1,0,0,0,        0,0,          0,0,          1,32'h300, 32'h300, 0,0,0); // stall in WAIT
        add(1,1,0,0,        0,0,          0,0,          1,32'h300, 32'h304, 1,0,0);
        add(0,1,0,0,        0,0,          1,32'h401,    1,32'h304, 32'h400, 1,1,0);
        add(0,1,0,0,        1,32'hFFFF_FFFE, 0,0,       1,32'h400, 32'hFFFF_FFFC, 1,1,0);
        add(0,1,0,0,        0,0,          0,0,          1,32'hFFFF_FFFC, 32'h0, 1,0,0); // wrap
        add(0,0,0,0,        0,0,          0,0,          1,32'h0,   32'h0,   0,0,0);
        add(0,0,0,0,        0,0,          1,32'h500,    1,32'h0,   32'h0,   0,0,0);
        add(0,0,0,0,        1,32'h600,    0,0,          1,32'h0,   32'h0,   0,0,0);
        add(0,0,0,0,        1,32'h650,    0,0,          1,32'h0,   32'h0,   0,0,0);
        add(0,0,0,0,        0,0,          1,32'h700,    1,32'h0,   32'h0,   0,0,0);
        add(0,1,0,0,        0,0,          0,0,          1,32'h0,   32'h650, 1,1,0);
        add(0,1,1,32'h800,  0,0,          0,0,          1,32'h650, 32'h800, 1,0,1);
        add(0,1,1,32'h880,  0,0,          1,32'h900,    1,32'h800, 32'h900, 1,1,0);
        add(0,1,0,0,        0,0,          0,0,          1,32'h900, 32'h904, 1,0,0);

        cpu_rstn = 1'b0;
        drive(vecs[0]);
        repeat (2) @(negedge cpu_clk);
        e = '{req:0, addr:32'h0, npc:32'h0, fire:0, kill:0, fpt:0};
        chk_all("reset", e);

        cpu_rstn = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge cpu_clk);
            drive(vecs[i]);
            sb.push_back(vecs[i].e);
            #4;
            e = sb.pop_front();
            chk_all($sformatf("v%0d", i), e);
        end

        // reset asserted mid-WAIT drops the outstanding request at once
        @(negedge cpu_clk);
        drive(vecs[0]);
        imem_gnt = 1'b0;
        @(negedge cpu_clk);
        #2;
        imem_gnt = 1'b1;
        cpu_rstn = 1'b0;
        #1;
        e = '{req:0, addr:32'h0, npc:32'h0, fire:0, kill:0, fpt:0};
        chk_all("rst_wait", e);
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        #4;
        chk_all("boot2", e);
        @(negedge cpu_clk);
        #4;
        e = '{req:1, addr:32'h0, npc:32'h4, fire:1, kill:0, fpt:0};
        chk_all("run2", e);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter AW, default `ADDR_WIDTH, meaning the width of every address port.
REQ-003 SHALL have port cpu_clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port cpu_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port stall_fetch, input, 1 bit: downstream stall; blocks issue of new requests.
REQ-006 SHALL have port imem_req, output, 1 bit: fetch request valid.
REQ-007 SHALL have port imem_addr, output, AW bits: fetch address; equals pc.
REQ-008 SHALL have port imem_gnt, input, 1 bit: fetch request accepted.
REQ-009 SHALL have port next_pc, output, AW bits: combinational next fetch address; drives the predictor read index.
REQ-010 SHALL have port pc, output, AW bits: registered current fetch address; drives the predictor tag compare.
REQ-011 SHALL have port predict_taken, input, 1 bit: predictor taken, aligned with pc.
REQ-012 SHALL have port predict_target_pc, input, AW bits: predicted target, aligned with pc.
REQ-013 SHALL have ports redirect_ex, input, 1 bit, and redirect_ex_pc, input, AW bits: execute-stage mispredict or jalr redirect and its target.
REQ-014 SHALL have ports redirect_dec, input, 1 bit, and redirect_dec_pc, input, AW bits: decode-stage jal redirect and its target.
REQ-015 SHALL have port fetch_fire, output, 1 bit: imem_req && imem_gnt this cycle.
REQ-016 SHALL have port fetch_kill, output, 1 bit: the firing fetch is wrong-path and must be discarded downstream.
REQ-017 SHALL have port fetch_pred_taken, output, 1 bit: predict_taken && fetch_fire && !fetch_kill; carried downstream as predict_taken for the instruction.

Function
REQ-018 SHALL implement FSM states BOOT, RUN and WAIT.
REQ-019 SHALL move BOOT->RUN unconditionally; BOOT lasts exactly one cycle after reset release, with imem_req=0.
REQ-020 SHALL, in RUN, drive imem_req=!stall_fetch, and move RUN->WAIT when imem_req && !imem_gnt.
REQ-021 SHALL, in WAIT, hold imem_req=1 regardless of stall_fetch, hold imem_addr stable, and move WAIT->RUN on imem_gnt.
REQ-022 SHALL define the effective redirect by priority: live redirect_ex, then live redirect_dec, then the pending redirect register.
REQ-023 SHALL compute next_pc on fire by priority: effective redirect target, then predict_target_pc if predict_taken, then pc+4 (mod 2^AW, wrap at all-ones).
REQ-024 SHALL set next_pc=pc when not firing.
REQ-025 SHALL force bits [1:0] of every selected target to 2'b00.
REQ-026 SHALL load pc with next_pc on fire only; pc holds otherwise.
REQ-027 SHALL, when a live redirect occurs while not firing, latch it into the pending register (pend_valid, pend_pc).
REQ-028 SHALL let a live ex redirect overwrite a pending dec redirect, and SHALL NOT let a dec redirect overwrite a pending ex redirect.
REQ-029 SHALL let a newer ex redirect overwrite an older pending ex redirect.
REQ-030 SHALL clear pend_valid on fire.
REQ-031 SHALL assert fetch_kill when fetch_fire and an effective redirect exists in the same cycle.
REQ-032 SHALL, on simultaneous redirect_ex and redirect_dec, use redirect_ex and ignore redirect_dec.
REQ-033 SHALL have a latency of 1 cycle from a redirect on a firing cycle to the redirected address appearing on imem_addr.

Reset
REQ-034 SHALL, while cpu_rstn=0, hold state=BOOT, pc=RESET_PC, pend_valid=0, pend_pc=0, imem_req=0, fetch_fire=0, fetch_kill=0, fetch_pred_taken=0.
REQ-035 SHALL, when reset is asserted mid-WAIT, abandon the outstanding request immediately with no completion.

Structure
REQ-036 SHALL place the FSM state encoding and RESET_PC default in the shared core defines package; ADDR_WIDTH comes from core_defines.vh.
REQ-037 SHALL contain no sub-module; the pending-redirect register is inline.

Verification
REQ-038 SHALL cover reset release with gnt=1 and no prediction: imem_req=0 for one cycle, then imem_addr 0x0,0x4,0x8 on consecutive cycles.
REQ-039 SHALL cover predict_taken=1 with target 0x103 at pc=0x8: next imem_addr=0x100 and fetch_pred_taken=1 for 0x8.
REQ-040 SHALL cover gnt=0 for 3 cycles at pc=0x10, with redirect_ex to 0x200 in cycle 2: imem_addr stays 0x10; on gnt, fetch_kill=1 and the next imem_addr is 0x200.
REQ-041 SHALL cover redirect_ex to 0x300 and redirect_dec to 0x400 in the same fire cycle: next imem_addr=0x300 and fetch_kill=1.
REQ-042 SHALL cover stall_fetch=1 in RUN: imem_req=0 and pc frozen; a stall asserted in WAIT leaves imem_req=1 until gnt.
REQ-043 SHALL cover pc=0xFFFF_FFFC with sequential fire: next imem_addr=0x0.
